// File: rtl/imem_stream_loader.sv
// Streams bytes from a host link into the core's instruction memory, one ins_write per little-endian word.
// Optional inter-byte timeout abort: define LOADER_TIMEOUT_EN.
module imem_stream_loader #(
  parameter int ADDR_W  = 10,
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   len_words,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              ins_write,
  output logic [WORD_W-1:0] instruction_in,
  output logic [ADDR_W:0]   wr_count,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int BYTES = WORD_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t             state;
  logic [ADDR_W:0]    len_q;
  logic [ADDR_W:0]    len_clamp;
  logic [ADDR_W:0]    wr_next;
  logic [IDX_W-1:0]   idx;
  logic [WORD_W-1:0]  asm_q;
  logic [WORD_W-1:0]  asm_nxt;
  logic               accept;
  logic               last_byte;
  logic               tmo_hit;

  assign byte_ready = (state == COLLECT);
  assign accept     = byte_valid && byte_ready;
  assign last_byte  = (idx == IDX_W'(BYTES - 1));
  assign len_clamp  = (len_words > MAX_LEN) ? MAX_LEN : len_words;
  assign wr_next    = wr_count + (ADDR_W+1)'(1);

  // Merge the incoming byte so the final byte lands in the strobed word the same edge.
  always_comb begin
    asm_nxt = asm_q;
    asm_nxt[8*idx +: 8] = byte_in;
  end

`ifdef LOADER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt;

  assign tmo_hit = (state == COLLECT) && !accept && (tmo_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              tmo_cnt <= '0;
    else if (state != COLLECT || accept)   tmo_cnt <= '0;
    else                                   tmo_cnt <= tmo_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 err <= 1'b0;
    else if (state == IDLE && load_start)     err <= 1'b0;
    else if (tmo_hit)                         err <= 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      len_q          <= '0;
      idx            <= '0;
      asm_q          <= '0;
      instruction_in <= '0;
      ins_write      <= 1'b0;
      wr_count       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            len_q    <= len_clamp;
            wr_count <= '0;
            idx      <= '0;
            busy     <= 1'b1;
            if (len_clamp == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (tmo_hit) begin
            // Abort: drop the partial word, no done pulse.
            state <= IDLE;
            busy  <= 1'b0;
            idx   <= '0;
          end else if (accept) begin
            asm_q <= asm_nxt;
            if (last_byte) begin
              idx            <= '0;
              instruction_in <= asm_nxt;
              ins_write      <= 1'b1;
              state          <= WRITE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        WRITE: begin
          ins_write <= 1'b0;
          wr_count  <= wr_next;
          if (wr_next == len_q) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= COLLECT;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed load sequences with random bytes/gaps, checked against a byte-to-word reference model.
module tb_imem_stream_loader;
  localparam int ADDR_W = 3;
  localparam int WORD_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              load_start = 1'b0;
  logic [ADDR_W:0]   len_words = '0;
  logic [7:0]        byte_in = '0;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic              ins_write;
  logic [WORD_W-1:0] instruction_in;
  logic [ADDR_W:0]   wr_count;
  logic              busy, done, err;

  imem_stream_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .len_words(len_words),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .ins_write(ins_write), .instruction_in(instruction_in), .wr_count(wr_count),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: cumulative records, the main sequence works on deltas.
  logic [31:0] got_w[$];
  int          str_cyc[$];
  int          n_done = 0, b2b = 0, br_bad = 0, busy_bad = 0, err_cyc = -1;
  logic        prev_iw = 0, prev_done = 0, prev_err = 0;
  always @(negedge clk) begin
    if (rst) begin
      if (ins_write) begin got_w.push_back(instruction_in); str_cyc.push_back(cyc); end
      if (ins_write && prev_iw) b2b++;
      if (byte_ready && (!busy || ins_write || done)) br_bad++;
      if (prev_done && busy) busy_bad++;
      if (done) n_done++;
      if (err && !prev_err) err_cyc = cyc;
    end
    prev_iw   <= rst && ins_write;
    prev_done <= rst && done;
    prev_err  <= rst && err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int last_acc = 0;

  task automatic start(input int len);
    @(negedge clk);
    len_words  = (ADDR_W+1)'(len);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] bs[$], input bit gaps);
    foreach (bs[i]) begin
      int  budget = 0;
      bit  acc = 0;
      while (!acc) begin
        @(negedge clk);
        byte_in    = bs[i];
        byte_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        acc = byte_valid && byte_ready;
        if (acc) last_acc = cyc + 1;
        budget++;
        if (budget > 200) begin
          chk("byte_accept_timeout", 32'(budget), 32'd0);
          byte_valid = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int budget = 0;
    while (busy && budget < 300) begin @(negedge clk); budget++; end
    if (busy) chk({tag, "_idle_timeout"}, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  // Reference model: words are consecutive 4-byte groups, first byte least significant.
  task automatic check_words(input string tag, input logic [7:0] bs[$], input int nwords, input int base);
    chk({tag, "_strobes"}, 32'(got_w.size() - base), 32'(nwords));
    for (int w = 0; w < nwords && base + w < got_w.size(); w++) begin
      logic [31:0] exp = 0;
      for (int k = 0; k < 4; k++) exp += 32'(bs[4*w+k]) << (8*k);
      chk($sformatf("%s_word%0d", tag, w), got_w[base+w], exp);
    end
  endtask

  function automatic void rand_bytes(output logic [7:0] q[$], input int n);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endfunction

  initial begin
    logic [7:0] bs[$];
    int base, dbase, mingap;

    // Reset state
    #3;
    chk("rst_byte_ready", 32'(byte_ready), 0);
    chk("rst_ins_write", 32'(ins_write), 0);
    chk("rst_instr", instruction_in, 0);
    chk("rst_wr_count", 32'(wr_count), 0);
    chk("rst_busy_done_err", {29'd0, busy, done, err}, 0);
    @(negedge clk); rst = 1'b1;

    // Two-word back-to-back stream
    base = got_w.size(); dbase = n_done;
    bs = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    start(2);
    chk("t1_busy", 32'(busy), 1);
    send(bs, 0);
    wait_idle("t1");
    check_words("t1", bs, 2, base);
    mingap = 1000;
    for (int i = base + 1; i < str_cyc.size(); i++)
      if (str_cyc[i] - str_cyc[i-1] < mingap) mingap = str_cyc[i] - str_cyc[i-1];
    chk("t1_spacing_ge5", 32'(mingap >= 5), 1);
    chk("t1_wr_count", 32'(wr_count), 2);
    chk("t1_done_pulses", 32'(n_done - dbase), 1);

    // Zero-length load
    base = got_w.size(); dbase = n_done;
    start(0);
    wait_idle("t2");
    chk("t2_strobes", 32'(got_w.size() - base), 0);
    chk("t2_done_pulses", 32'(n_done - dbase), 1);
    chk("t2_wr_count", 32'(wr_count), 0);

    // Random gaps, four words
    base = got_w.size();
    rand_bytes(bs, 16);
    start(4);
    send(bs, 1);
    wait_idle("t3");
    check_words("t3", bs, 4, base);
    chk("t3_wr_count", 32'(wr_count), 4);

    // Second load_start while busy is ignored
    base = got_w.size();
    rand_bytes(bs, 12);
    start(3);
    start(7);
    send(bs, 1);
    wait_idle("t4");
    check_words("t4", bs, 3, base);
    chk("t4_wr_count", 32'(wr_count), 3);
    chk("t4_ready_idle", 32'(byte_ready), 0);

    // Reset mid-load, then a fresh one-word load
    rand_bytes(bs, 6);
    start(3);
    send(bs, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_wr_count", 32'(wr_count), 0);
    @(negedge clk); rst = 1'b1;
    base = got_w.size();
    bs = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    start(1);
    send(bs, 1);
    wait_idle("t5");
    check_words("t5", bs, 1, base);
    chk("t5_wr_count", 32'(wr_count), 1);

    // Over-long length clamps to 2**ADDR_W words
    base = got_w.size();
    rand_bytes(bs, 32);
    start(13);
    send(bs, 1);
    wait_idle("t6");
    check_words("t6", bs, 8, base);
    chk("t6_wr_count", 32'(wr_count), 8);
    byte_valid = 1'b1;
    repeat (4) @(negedge clk);
    byte_valid = 1'b0;
    chk("t6_no_extra", 32'(got_w.size() - base), 8);

`ifdef LOADER_TIMEOUT_EN
    // Stall mid-word: abort after TIMEOUT cycles without done
    base = got_w.size(); dbase = n_done; err_cyc = -1;
    rand_bytes(bs, 5);
    start(2);
    send(bs, 0);
    wait_idle("t7");
    chk("t7_strobes", 32'(got_w.size() - base), 1);
    chk("t7_err", 32'(err), 1);
    chk("t7_err_delay", 32'(err_cyc - last_acc), 16);
    chk("t7_no_done", 32'(n_done - dbase), 0);
    start(0);
    chk("t7_err_cleared", 32'(err), 0);
    wait_idle("t7b");
`else
    chk("err_tied_low", 32'(err), 0);
`endif

    chk("never_back_to_back", 32'(b2b), 0);
    chk("ready_only_collect", 32'(br_bad), 0);
    chk("busy_drops_after_done", 32'(busy_bad), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
